// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Parametrised pipeline boundary register with valid/ready flow control.
//   It carries a payload, a destination register index and control bits from
//   one pipeline stage to the next. It is used at the IF/ID, ID/EX, EX/MEM
//   and MEM/WB boundaries and replaces the older fixed-width MEM/WB latch.
//
//   Handshake: an entry moves across a port on a rising clk edge where
//   valid and ready are both 1. The sender holds valid and its payload
//   stable until that edge. The receiver may change ready at any time.
//   Neither side makes valid depend on ready.
//
//   When the stage holds no valid entry (a bubble), out_ctrl is forced to
//   zero. A stalled or flushed boundary therefore never causes a register
//   write or a memory access downstream.
//
//   SKID = 1 : two-entry stage. in_ready comes straight from a flop, so
//              there is no combinational path from out_ready to in_ready.
//   SKID = 0 : single-entry stage. in_ready = out_ready | ~out_valid.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; overrides flush and
//                   all handshakes
//   flush      in   synchronous; drops the held entries and any entry
//                   accepted in the same cycle
//   in_valid   in   upstream entry present
//   in_ready   out  stage accepts an entry this cycle
//   in_data    in   upstream payload            [DATA_W-1:0]
//   in_dest    in   upstream destination index  [DEST_W-1:0]
//   in_ctrl    in   upstream control bits       [CTRL_W-1:0]
//   out_valid  out  head entry present
//   out_ready  in   downstream consumes the head entry this cycle
//   out_data   out  head payload (holds its last value in a bubble)
//   out_dest   out  head destination (holds its last value in a bubble)
//   out_ctrl   out  head control bits, 0 whenever out_valid = 0
//   stall_cnt  out  saturating count of edges with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int DEST_W = 5,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // Head entry: the one currently presented on out_*.
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic [DEST_W-1:0] head_dest_q,  head_dest_d;
    logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;

    // Skid entry: catches an entry accepted while the head is blocked.
    // Only written when SKID = 1.
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [DEST_W-1:0] skid_dest_q,  skid_dest_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Registered in_ready for the two-entry variant. It always equals the
    // inverse of the skid valid bit. It is kept as its own flop so that
    // in_ready leaves the block straight from a register.
    logic              in_ready_q,   in_ready_d;

    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    // -----------------------------------------------------------------------
    // Handshake events for this cycle
    // -----------------------------------------------------------------------
    logic accept;
    logic consume;

    always_comb begin
        if (SKID != 0) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = out_ready | ~head_valid_q;
        end
    end

    assign accept  = in_valid & in_ready;
    assign consume = head_valid_q & out_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_dest_d  = head_dest_q;
        head_ctrl_d  = head_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_dest_d  = skid_dest_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            // Flush drops everything, including an entry that is handshaked
            // in the same cycle. The payload fields keep their old values
            // because they are don't-care once valid is cleared.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (consume) begin
                if (skid_valid_q) begin
                    // The skid entry is older than anything upstream, so it
                    // goes to the head first. in_ready was low this cycle,
                    // so no accept can happen at the same time.
                    head_data_d  = skid_data_q;
                    head_dest_d  = skid_dest_q;
                    head_ctrl_d  = skid_ctrl_q;
                    head_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    head_data_d  = in_data;
                    head_dest_d  = in_dest;
                    head_ctrl_d  = in_ctrl;
                    head_valid_d = 1'b1;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (head_valid_q) begin
                    // Head is blocked downstream: park the new entry.
                    skid_data_d  = in_data;
                    skid_dest_d  = in_dest;
                    skid_ctrl_d  = in_ctrl;
                    skid_valid_d = 1'b1;
                end else begin
                    head_data_d  = in_data;
                    head_dest_d  = in_dest;
                    head_ctrl_d  = in_ctrl;
                    head_valid_d = 1'b1;
                end
            end
        end else begin
            // Single entry: in_ready already includes out_ready, so an
            // accept always finds the head free or being drained.
            if (accept) begin
                head_data_d  = in_data;
                head_dest_d  = in_dest;
                head_ctrl_d  = in_ctrl;
                head_valid_d = 1'b1;
            end else if (consume) begin
                head_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready_d = ~skid_valid_d;
    end

    // A stall is an edge where an entry is presented and not taken.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_dest_q  <= '0;
            head_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_dest_q  <= '0;
            skid_ctrl_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_dest_q  <= head_dest_d;
            head_ctrl_q  <= head_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_dest_q  <= skid_dest_d;
            skid_ctrl_q  <= skid_ctrl_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_dest  = head_dest_q;
    // Bubbles carry no control so downstream never writes on them.
    assign out_ctrl  = head_valid_q ? head_ctrl_q : {CTRL_W{1'b0}};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives a two-entry (SKID=1) instance and a single-entry (SKID=0) instance
// of pipe_stage_reg with directed vectors. A per-instance monitor records
// every handshaked input entry in an expected queue. The monitor pops and
// compares that queue on each downstream consume, which checks ordering,
// loss and duplication. The stimulus thread also checks outputs directly
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int DEST_W = 5;
    localparam int CTRL_W = 2;
    localparam int CNT_W  = 16;
    localparam int ENT_W  = DATA_W + DEST_W + CTRL_W;

    // Clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SKID=1 instance signals
    logic              s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DATA_W-1:0] s_in_data, s_out_data;
    logic [DEST_W-1:0] s_in_dest, s_out_dest;
    logic [CTRL_W-1:0] s_in_ctrl, s_out_ctrl;
    logic [CNT_W-1:0]  s_stall_cnt;

    // SKID=0 instance signals
    logic              n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [DATA_W-1:0] n_in_data, n_out_data;
    logic [DEST_W-1:0] n_in_dest, n_out_dest;
    logic [CTRL_W-1:0] n_in_ctrl, n_out_ctrl;
    logic [CNT_W-1:0]  n_stall_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)
    ) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_dest(s_in_dest), .in_ctrl(s_in_ctrl),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_dest(s_out_dest), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(CNT_W)
    ) u_noskid (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .in_dest(n_in_dest), .in_ctrl(n_in_ctrl),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .out_dest(n_out_dest), .out_ctrl(n_out_ctrl),
        .stall_cnt(n_stall_cnt)
    );

    // Scoreboard
    int checks = 0;
    int errors = 0;
    logic [ENT_W-1:0] s_exp_q[$];
    logic [ENT_W-1:0] n_exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors sample at the falling edge. The handshakes they see there
    // are the ones the next rising edge performs. Pop first, then push, so
    // an entry is never compared against itself.
    always @(negedge clk) begin : mon_skid
        logic [ENT_W-1:0] exp_ent;
        if (rst) begin
            s_exp_q.delete();
        end else begin
            if (s_out_valid && s_out_ready) begin
                checks++;
                if (s_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL skid_extra: got 0x%0h expected no entry",
                             {s_out_data, s_out_dest, s_out_ctrl});
                end else begin
                    exp_ent = s_exp_q.pop_front();
                    if ({s_out_data, s_out_dest, s_out_ctrl} !== exp_ent) begin
                        errors++;
                        $display("FAIL skid_order: got 0x%0h expected 0x%0h",
                                 {s_out_data, s_out_dest, s_out_ctrl}, exp_ent);
                    end
                end
            end
            if (s_flush) s_exp_q.delete();
            else if (s_in_valid && s_in_ready) s_exp_q.push_back({s_in_data, s_in_dest, s_in_ctrl});
        end
    end

    always @(negedge clk) begin : mon_noskid
        logic [ENT_W-1:0] exp_ent;
        if (rst) begin
            n_exp_q.delete();
        end else begin
            if (n_out_valid && n_out_ready) begin
                checks++;
                if (n_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL noskid_extra: got 0x%0h expected no entry",
                             {n_out_data, n_out_dest, n_out_ctrl});
                end else begin
                    exp_ent = n_exp_q.pop_front();
                    if ({n_out_data, n_out_dest, n_out_ctrl} !== exp_ent) begin
                        errors++;
                        $display("FAIL noskid_order: got 0x%0h expected 0x%0h",
                                 {n_out_data, n_out_dest, n_out_ctrl}, exp_ent);
                    end
                end
            end
            if (n_flush) n_exp_q.delete();
            else if (n_in_valid && n_in_ready) n_exp_q.push_back({n_in_data, n_in_dest, n_in_ctrl});
        end
    end

    // Driver helpers: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_drive(input logic v, input logic [DATA_W-1:0] d,
                           input logic [DEST_W-1:0] ds, input logic [CTRL_W-1:0] c);
        s_in_valid = v;
        s_in_data  = d;
        s_in_dest  = ds;
        s_in_ctrl  = c;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_flush = 1'b0; s_out_ready = 1'b0; s_drive(1'b0, '0, '0, '0);
        n_flush = 1'b0; n_out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_in_dest = '0; n_in_ctrl = '0;
        repeat (2) tick();
        rst = 1'b0;

        // ---- Reset state ----
        chk("rst_out_valid", {63'd0, s_out_valid}, 64'd0);
        chk("rst_out_data",  s_out_data, 64'd0);
        chk("rst_out_dest",  {59'd0, s_out_dest}, 64'd0);
        chk("rst_out_ctrl",  {62'd0, s_out_ctrl}, 64'd0);
        chk("rst_stall",     {48'd0, s_stall_cnt}, 64'd0);
        chk("rst_in_ready",  {63'd0, s_in_ready}, 64'd1);
        chk("rst_n_in_ready", {63'd0, n_in_ready}, 64'd1);

        // ---- Streaming ----
        s_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_drive(1'b1, 64'(i), 5'(i), 2'b01);
            tick();
            chk("stream_in_ready", {63'd0, s_in_ready}, 64'd1);
            chk("stream_valid",    {63'd0, s_out_valid}, 64'd1);
            chk("stream_data",     s_out_data, 64'(i));
        end
        s_drive(1'b0, '0, '0, '0);
        tick();
        chk("stream_drained", {63'd0, s_out_valid}, 64'd0);
        chk("stream_stall",   {48'd0, s_stall_cnt}, 64'd0);

        // ---- Backpressure ----
        s_out_ready = 1'b0;
        s_drive(1'b1, 64'hAA, 5'd3, 2'b11);
        tick();
        s_drive(1'b1, 64'hBB, 5'd4, 2'b11);
        tick();
        s_drive(1'b0, '0, '0, '0);
        chk("bp_in_ready_low", {63'd0, s_in_ready}, 64'd0);
        tick();
        tick();
        chk("bp_head_hold",  s_out_data, 64'hAA);
        chk("bp_ctrl_hold",  {62'd0, s_out_ctrl}, 64'd3);
        chk("bp_stall3",     {48'd0, s_stall_cnt}, 64'd3);
        chk("bp_in_ready_still_low", {63'd0, s_in_ready}, 64'd0);
        s_out_ready = 1'b1;
        tick();
        chk("bp_second_data",  s_out_data, 64'hBB);
        chk("bp_second_valid", {63'd0, s_out_valid}, 64'd1);
        chk("bp_in_ready_back", {63'd0, s_in_ready}, 64'd1);
        tick();
        chk("bp_drained", {63'd0, s_out_valid}, 64'd0);
        chk("bp_stall_kept", {48'd0, s_stall_cnt}, 64'd3);

        // ---- Flush with two entries held, C offered upstream ----
        s_out_ready = 1'b0;
        s_drive(1'b1, 64'h11, 5'd1, 2'b11);
        tick();
        s_drive(1'b1, 64'h22, 5'd2, 2'b11);
        tick();
        s_drive(1'b1, 64'hCC, 5'd5, 2'b11);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        s_drive(1'b0, '0, '0, '0);
        chk("flush_valid",    {63'd0, s_out_valid}, 64'd0);
        chk("flush_ctrl",     {62'd0, s_out_ctrl}, 64'd0);
        chk("flush_in_ready", {63'd0, s_in_ready}, 64'd1);
        chk("flush_stall_kept", {48'd0, s_stall_cnt}, 64'd5);
        tick();
        chk("flush_no_c", {63'd0, s_out_valid}, 64'd0);

        // ---- Flush discards a same-cycle accept ----
        s_drive(1'b1, 64'hDD, 5'd6, 2'b10);
        s_flush = 1'b1;
        chk("flush_acc_in_ready", {63'd0, s_in_ready}, 64'd1);
        tick();
        s_flush = 1'b0;
        s_drive(1'b0, '0, '0, '0);
        chk("flush_acc_dropped", {63'd0, s_out_valid}, 64'd0);

        // ---- Bubble control ----
        for (int i = 0; i < 5; i++) begin
            s_drive(1'b0, 64'hEE, 5'd9, 2'b11);
            s_out_ready = (i % 2) == 0;
            tick();
            chk("bubble_ctrl",  {62'd0, s_out_ctrl}, 64'd0);
            chk("bubble_valid", {63'd0, s_out_valid}, 64'd0);
        end

        // ---- Reset mid-operation with flush also asserted ----
        s_out_ready = 1'b0;
        s_drive(1'b1, 64'hF1, 5'd1, 2'b11);
        tick();
        s_drive(1'b1, 64'hF2, 5'd2, 2'b11);
        tick();
        s_drive(1'b0, '0, '0, '0);
        tick();
        chk("pre_rst_stall7", {48'd0, s_stall_cnt}, 64'd7);
        rst = 1'b1;
        s_flush = 1'b1;
        s_drive(1'b1, 64'h99, 5'd7, 2'b11);
        tick();
        rst = 1'b0;
        s_flush = 1'b0;
        s_drive(1'b0, '0, '0, '0);
        chk("mid_rst_valid",    {63'd0, s_out_valid}, 64'd0);
        chk("mid_rst_data",     s_out_data, 64'd0);
        chk("mid_rst_dest",     {59'd0, s_out_dest}, 64'd0);
        chk("mid_rst_ctrl",     {62'd0, s_out_ctrl}, 64'd0);
        chk("mid_rst_stall",    {48'd0, s_stall_cnt}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, s_in_ready}, 64'd1);
        tick();
        chk("mid_rst_dropped",  {63'd0, s_out_valid}, 64'd0);

        // ---- Flush together with consume: head delivered, skid dropped ----
        s_drive(1'b1, 64'h71, 5'd3, 2'b01);
        tick();
        s_drive(1'b1, 64'h72, 5'd4, 2'b01);
        tick();
        s_drive(1'b0, '0, '0, '0);
        s_out_ready = 1'b1;
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        chk("flush_cons_valid",    {63'd0, s_out_valid}, 64'd0);
        chk("flush_cons_in_ready", {63'd0, s_in_ready}, 64'd1);
        tick();
        chk("flush_cons_nothing",  {63'd0, s_out_valid}, 64'd0);
        chk("flush_cons_stall",    {48'd0, s_stall_cnt}, 64'd1);

        // ---- SKID=0: combinational in_ready ----
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_data = 64'h55; n_in_dest = 5'd7; n_in_ctrl = 2'b10;
        tick();
        chk("n_loaded",        {63'd0, n_out_valid}, 64'd1);
        chk("n_in_ready_low",  {63'd0, n_in_ready}, 64'd0);
        n_in_data = 64'h66; n_in_dest = 5'd8; n_in_ctrl = 2'b01;
        n_out_ready = 1'b1;
        #1;
        chk("n_in_ready_comb", {63'd0, n_in_ready}, 64'd1);
        tick();
        chk("n_replace_valid", {63'd0, n_out_valid}, 64'd1);
        chk("n_replace_data",  n_out_data, 64'h66);
        chk("n_replace_ctrl",  {62'd0, n_out_ctrl}, 64'd1);

        // ---- SKID=0: stall counter saturation ----
        n_in_valid = 1'b0;
        n_out_ready = 1'b0;
        tick();
        chk("n_stall1", {48'd0, n_stall_cnt}, 64'd1);
        repeat (65533) tick();
        chk("n_stall_fffe", {48'd0, n_stall_cnt}, 64'hFFFE);
        tick();
        chk("n_stall_ffff", {48'd0, n_stall_cnt}, 64'hFFFF);
        repeat (5) tick();
        chk("n_stall_sat",  {48'd0, n_stall_cnt}, 64'hFFFF);
        chk("n_head_hold",  n_out_data, 64'h66);
        n_out_ready = 1'b1;
        tick();
        chk("n_drained",      {63'd0, n_out_valid}, 64'd0);
        chk("n_bubble_ctrl",  {62'd0, n_out_ctrl}, 64'd0);

        // ---- SKID=0: flush drops a same-cycle accept ----
        n_in_valid = 1'b1; n_in_data = 64'h77; n_in_dest = 5'd2; n_in_ctrl = 2'b11;
        n_flush = 1'b1;
        tick();
        n_flush = 1'b0;
        n_in_valid = 1'b0;
        chk("n_flush_dropped", {63'd0, n_out_valid}, 64'd0);
        chk("n_flush_ctrl",    {62'd0, n_out_ctrl}, 64'd0);
        tick();

        // Every accepted entry must have been delivered or flushed.
        chk("skid_queue_empty",   64'(s_exp_q.size()), 64'd0);
        chk("noskid_queue_empty", 64'(n_exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-width MEM/WB latch.
- Carries payload, destination register index and control bits between pipeline stages, using valid/ready flow control, flush-to-bubble and an optional skid buffer.
- Control bits are forced to zero on bubbles, so a stalled or flushed stage never triggers a register write downstream.
- Used for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
- DATA_W, 64, payload width (e.g. {aluOut, memOut} for MEM/WB).
- DEST_W, 5, destination GPR index width.
- CTRL_W, 2, control-bit width (e.g. {regW, memToR}); zeroed whenever the stage holds no valid entry.
- SKID, 1, 1 = two-entry stage with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous: discard all held and incoming entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage accepts an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_dest  input  DEST_W  upstream destination index.
- in_ctrl  input  CTRL_W  upstream control bits.
- out_valid  output  1  downstream entry present.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_data  output  DATA_W  payload of the head entry.
- out_dest  output  DEST_W  destination of the head entry.
- out_ctrl  output  CTRL_W  control bits of the head entry; 0 when out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_dest=0, out_ctrl=0, stall_cnt=0.
  - Skid entry invalid.
  - in_ready=1 in the cycle after reset.
  - rst has priority over flush and over all handshakes.
- Transfer rules:
  - Upstream accept occurs when in_valid & in_ready at the edge.
  - Downstream consume occurs when out_valid & out_ready at the edge.
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N, if the head slot is free or being consumed at edge N.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Head loads on accept. Head clears valid on a consume without an accept.
- SKID=1:
  - in_ready = ~skid_valid, driven from a flop; there is no combinational out_ready->in_ready path.
  - Accept while the head is held (out_valid & ~out_ready) writes the skid entry.
  - Consume with skid_valid moves skid to head and clears skid_valid.
  - Consume with no skid and a simultaneous accept loads head from input.
  - Order is strict FIFO. No entry is lost or duplicated.
- Head hold: when out_valid & ~out_ready, out_data, out_dest and out_ctrl are stable until consumed or flushed.
- Bubble: when out_valid=0, out_ctrl=0. out_data and out_dest retain their last values (don't-care).
- Flush (rst=0, flush=1 at edge):
  - Head and skid valid cleared; out_ctrl=0.
  - An accept in the same cycle is discarded. in_ready is still reported that cycle (upstream sees the handshake) but the data is dropped.
  - in_ready=1 in the next cycle.
- stall_cnt: increments at each edge where out_valid=1 and out_ready=0. Saturates at 2^CNT_W-1. Cleared only by rst; flush does not clear it.
- Simultaneous flush and consume: flush wins; the consumed entry counts as delivered for this cycle only, and nothing follows it.
- No X propagation: every register has a defined reset value.

Test Plan:
- Streaming (SKID=1, out_ready=1): in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles one cycle later; in_ready stays 1; stall_cnt=0.
- Backpressure: send A=0xAA then B=0xBB and drop out_ready for 3 cycles -> out_data holds 0xAA; B sits in the skid; in_ready=0 from the cycle after B is accepted; stall_cnt=3. Raise out_ready -> AA then BB, in order, on consecutive cycles.
- Flush: with two entries held (ctrl=2'b11) and in_valid=1 carrying C, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
- Bubble control: with in_valid=0 and in_ctrl=2'b11 for 5 cycles -> out_ctrl=0 and out_valid=0 throughout.
- Reset mid-operation: with a stalled stage holding 2 entries and stall_cnt=7, assert rst=1 for 1 cycle -> all outputs 0, stall_cnt=0, in_ready=1 next cycle; rst takes precedence if flush is also asserted.
- SKID=0 variant: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Then out_ready=1 with in_valid=1 -> replacement entry appears after one edge (zero bubbles); stall_cnt saturates at 0xFFFF after 65535+ stalled cycles.
